// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Reference function is written for up to 16 inputs and masked down to the live width.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_N_IN = 16;

  // Generalised AB+AC: top bit ANDed with the OR of all lower bits.
  function automatic logic exp_ab_ac(input logic [MAX_N_IN-1:0] v, input int unsigned n_in);
    logic [MAX_N_IN-1:0] a_mask;
    logic [MAX_N_IN-1:0] low_mask;
    a_mask   = MAX_N_IN'(1) << (n_in - 1);
    low_mask = a_mask - MAX_N_IN'(1);
    return (|(v & a_mask)) & (|(v & low_mask));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x, input logic [31:0] max_val);
    return (x >= max_val) ? x : x + 32'd1;
  endfunction

endpackage

// File: rtl/tts_hold_timer.sv
// Counts the cycles a stimulus vector has been held; last marks the sample cycle.
// Self-wraps to zero after the sample cycle so the next vector starts a fresh hold.
module tts_hold_timer #(
  parameter int unsigned HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned W = $clog2(HOLD + 1);

  logic [W-1:0] hold_cnt;

  assign last = (hold_cnt == W'(HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (clr) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= last ? '0 : hold_cnt + W'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector into an external gate, checks each response against AB+AC,
// and reports a saturating mismatch count plus the first failing vector.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned HOLD  = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic [N_IN-1:0]  vec_out,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec
);

  localparam logic [31:0] ERR_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t state, state_nxt;
  logic   accept;
  logic   sample;
  logic   last;
  logic   last_vec;
  logic   mismatch;

  assign last_vec = (vec_out == '1);
  assign mismatch = (dut_out != exp_ab_ac(MAX_N_IN'(vec_out), N_IN));
  assign pass     = done && (err_count == '0);

  tts_hold_timer #(.HOLD(HOLD)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (busy),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    vec_valid = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        vec_valid = 1'b1;
        sample    = last;
        if (last && last_vec) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Terminal test is all-ones, so vec_out never wraps and stays at all-ones in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out         <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (accept) begin
      vec_out         <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (sample) begin
      if (mismatch) begin
        err_count <= CNT_W'(sat_inc(32'(err_count), ERR_MAX));
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= vec_out;
        end
      end
      if (!last_vec) begin
        vec_out <= vec_out + N_IN'(1);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances cover default, narrow-counter and HOLD=1 configurations.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  logic [7:0]  tbl0;
  logic [15:0] tbl2;

  logic       dut_out0, vec_valid0, busy0, done0, pass0, fv0;
  logic [2:0] vec_out0, fev0;
  logic [7:0] err0;

  logic       dut_out1, vec_valid1, busy1, done1, pass1, fv1;
  logic [2:0] vec_out1, fev1;
  logic [1:0] err1;

  logic       dut_out2, vec_valid2, busy2, done2, pass2, fv2;
  logic [3:0] vec_out2, fev2;
  logic [7:0] err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign dut_out0 = tbl0[vec_out0];
  assign dut_out1 = ~(vec_out1[2] & (vec_out1[1] | vec_out1[0]));
  assign dut_out2 = tbl2[vec_out2];

  truth_table_sweeper #(.N_IN(3), .HOLD(10), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_out(dut_out0), .vec_out(vec_out0),
    .vec_valid(vec_valid0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_valid(fv0), .first_err_vec(fev0));

  truth_table_sweeper #(.N_IN(3), .HOLD(10), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_out(dut_out1), .vec_out(vec_out1),
    .vec_valid(vec_valid1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fv1), .first_err_vec(fev1));

  truth_table_sweeper #(.N_IN(4), .HOLD(1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .start(start2), .dut_out(dut_out2), .vec_out(vec_out2),
    .vec_valid(vec_valid2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(fv2), .first_err_vec(fev2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: expected bit is "A and any other input", computed arithmetically.
  function automatic bit ref_bit(input int v, input int n);
    return ((v >> (n - 1)) & 1) == 1 && (v & ((1 << (n - 1)) - 1)) != 0;
  endfunction

  function automatic void model_sweep(input logic [15:0] tbl, input int n, input int sat_max,
                                      output int err, output int first);
    err = 0;
    first = -1;
    for (int v = 0; v < (1 << n); v++) begin
      if (tbl[v] != ref_bit(v, n)) begin
        if (err < sat_max) err++;
        if (first < 0) first = v;
      end
    end
  endfunction

  task automatic run0(input string nm, input logic [7:0] tbl, input bit poke,
                      input int exp_err, input int exp_first, input bit exp_pass);
    int n;
    bit seq_ok;
    tbl0 = tbl;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    check({nm, ".clear_err"}, err0, 0);
    check({nm, ".clear_fv"}, fv0, 0);
    n = 0;
    seq_ok = 1'b1;
    while (!done0 && n < 200) begin
      if (vec_out0 != 3'(n / 10) || !vec_valid0 || !busy0) seq_ok = 1'b0;
      start0 = poke && (n == 25 || n == 65);
      @(negedge clk);
      n++;
    end
    start0 = 1'b0;
    check({nm, ".vec_seq"}, seq_ok, 1);
    check({nm, ".done_cycles"}, n, 80);
    check({nm, ".err_count"}, err0, exp_err);
    check({nm, ".first_valid"}, fv0, exp_first >= 0);
    check({nm, ".first_vec"}, fev0, exp_first >= 0 ? exp_first : 0);
    check({nm, ".pass"}, pass0, exp_pass);
    check({nm, ".final_vec"}, {vec_valid0, vec_out0}, 4'b0111);
  endtask

  task automatic run2(input string nm, input logic [15:0] tbl);
    int n, e_err, e_first;
    bit seq_ok;
    model_sweep(tbl, 4, 255, e_err, e_first);
    tbl2 = tbl;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    n = 0;
    seq_ok = 1'b1;
    while (!done2 && n < 100) begin
      if (vec_out2 != 4'(n) || !busy2) seq_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({nm, ".vec_seq"}, seq_ok, 1);
    check({nm, ".done_cycles"}, n, 16);
    check({nm, ".err_count"}, err2, e_err);
    check({nm, ".first_vec"}, {fv2, fev2}, e_first >= 0 ? {1'b1, 4'(e_first)} : 5'd0);
    check({nm, ".pass"}, pass2, e_err == 0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] tbl;
    bit         poke;
    int         exp_err;
    int         exp_first;
    bit         exp_pass;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n, e_err, e_first;
    logic [7:0] rt;

    vecs[0] = '{"correct",    8'hE0, 1'b0, 0, -1, 1'b1};
    vecs[1] = '{"stuck0",     8'h00, 1'b0, 3,  5, 1'b0};
    vecs[2] = '{"poke_run",   8'hE0, 1'b1, 0, -1, 1'b1};
    vecs[3] = '{"inverted",   8'h1F, 1'b0, 8,  0, 1'b0};
    vecs[4] = '{"ab_only",    8'hC0, 1'b0, 1,  5, 1'b0};

    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tbl0 = 8'hE0; tbl2 = 16'h0;
    repeat (2) @(negedge clk);
    check("reset.outs0", {vec_out0, vec_valid0, busy0, done0, pass0, err0, fv0, fev0}, 0);
    check("reset.outs2", {vec_out2, busy2, done2, pass2, err2, fv2, fev2}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle.no_start", {busy0, done0}, 0);

    for (int i = 0; i < 5; i++) begin
      run0(vecs[i].name, vecs[i].tbl, vecs[i].poke, vecs[i].exp_err, vecs[i].exp_first, vecs[i].exp_pass);
      repeat (3) @(negedge clk);
      check({vecs[i].name, ".done_held"}, {done0, busy0}, 2'b10);
    end

    for (int i = 0; i < 4; i++) begin
      rt = 8'($urandom);
      model_sweep({8'h0, rt}, 3, 255, e_err, e_first);
      run0($sformatf("rand%0d", i), rt, 1'b0, e_err, e_first, e_err == 0);
    end

    // Mid-sweep reset while vector 4 is driven, with four mismatches already counted.
    tbl0 = 8'h1F;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n = 0;
    while (vec_out0 != 3'd4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst.reach_vec4", vec_out0, 4);
    check("midrst.err_before", err0, 4);
    #2 rst = 1'b1;
    #1 check("midrst.async_outs", {vec_out0, vec_valid0, busy0, done0, pass0, err0, fv0, fev0}, 0);
    @(negedge clk) rst = 1'b0;
    run0("after_rst", 8'hE0, 1'b0, 0, -1, 1'b1);

    // Narrow counter: eight mismatches saturate at 3.
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    n = 0;
    while (!done1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sat.done_cycles", n, 80);
    check("sat.err_count", err1, 3);
    check("sat.first_vec", {fv1, fev1}, 4'b1000);
    check("sat.pass", pass1, 0);

    run2("hold1_correct", 16'hFE00);
    for (int i = 0; i < 3; i++) run2($sformatf("hold1_rand%0d", i), 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
